// File: rtl/online_add_sched.sv
// Round-robin scheduler that streams one requester's digit pair through a shared online adder.
// Latency: digit j reaches add_x/add_y one cycle after it is accepted; z_out trails it by ONLINE_DELAY+1 cycles.
// Backpressure: none; dig_rdy is the consume strobe. Optional ONLINE_ADD_SCHED_DIGIT_CHECK_EN scrubs 2'b11 digits and flags err.
module online_add_sched #(
  parameter int UNROLLING    = 64,
  parameter int ONLINE_DELAY = 2
) (
  input  logic       clk,
  input  logic       asyn_reset_n,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic [1:0] x0_in,
  input  logic [1:0] y0_in,
  input  logic [1:0] x1_in,
  input  logic [1:0] y1_in,
  output logic       dig_rdy,
  output logic [1:0] add_x,
  output logic [1:0] add_y,
  output logic       add_clr,
  input  logic [1:0] add_z,
  output logic [1:0] z_out,
  output logic       z_valid,
  output logic       z_last,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, CLR, STREAM, FLUSH, DRAIN, DONE} state_t;

  localparam int CW = $clog2(UNROLLING);
  localparam int DW = (ONLINE_DELAY > 1) ? $clog2(ONLINE_DELAY) : 1;
  localparam logic [CW-1:0] DIG_LAST = CW'(UNROLLING - 1);
  localparam logic [DW-1:0] DLY_LAST = DW'(ONLINE_DELAY - 1);

  state_t            state, state_nxt;
  logic              owner, last_srv, win;
  logic [CW-1:0]     dig_cnt;
  logic [DW-1:0]     dly_cnt;
  logic [1:0]        sel_x, sel_y, dig_x, dig_y;
  logic              tag_vld, tag_last;
  logic [ONLINE_DELAY-1:0] vld_sr, last_sr;

  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = CLR;
      CLR:     state_nxt = STREAM;
      STREAM:  if (dig_cnt == DIG_LAST) state_nxt = FLUSH;
      FLUSH:   if (dly_cnt == DLY_LAST) state_nxt = DRAIN;
      DRAIN:   if (z_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    gnt0    = busy && !owner;
    gnt1    = busy && owner;
    dig_rdy = (state == STREAM);
    add_clr = (state == CLR);
  end

  // Contention goes to whoever was not served last; a lone requester always wins.
  assign win = (req0 && req1) ? ~last_srv : req1;

  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      owner    <= 1'b0;
      last_srv <= 1'b1;
      dig_cnt  <= '0;
      dly_cnt  <= '0;
    end else begin
      if (state == IDLE && state_nxt == CLR) owner <= win;
      if (state == DONE) last_srv <= owner;
      if (state == CLR)
        dig_cnt <= '0;
      else if (state == STREAM && dig_cnt != DIG_LAST)
        dig_cnt <= dig_cnt + 1'b1;
      if (state == CLR || state == STREAM)
        dly_cnt <= '0;
      else if (state == FLUSH && dly_cnt != DLY_LAST)
        dly_cnt <= dly_cnt + 1'b1;
    end
  end

  assign sel_x = owner ? x1_in : x0_in;
  assign sel_y = owner ? y1_in : y0_in;

`ifdef ONLINE_ADD_SCHED_DIGIT_CHECK_EN
  logic bad_dig, err_q;

  assign bad_dig = (sel_x == 2'b11) || (sel_y == 2'b11);
  assign dig_x   = (sel_x == 2'b11) ? 2'b00 : sel_x;
  assign dig_y   = (sel_y == 2'b11) ? 2'b00 : sel_y;

  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n)
      err_q <= 1'b0;
    else if (state_nxt == CLR)
      err_q <= 1'b0;
    else if (state == STREAM && bad_dig)
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign dig_x = sel_x;
  assign dig_y = sel_y;
  assign err   = 1'b0;
`endif

  // Tags ride alongside the digits and are delayed to line up with the adder's result.
  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      add_x    <= 2'b00;
      add_y    <= 2'b00;
      tag_vld  <= 1'b0;
      tag_last <= 1'b0;
      vld_sr   <= '0;
      last_sr  <= '0;
      z_out    <= 2'b00;
      z_valid  <= 1'b0;
      z_last   <= 1'b0;
    end else begin
      add_x    <= (state == STREAM) ? dig_x : 2'b00;
      add_y    <= (state == STREAM) ? dig_y : 2'b00;
      tag_vld  <= (state == STREAM) || (state == FLUSH);
      tag_last <= (state == FLUSH) && (dly_cnt == DLY_LAST);
      vld_sr[0]  <= tag_vld;
      last_sr[0] <= tag_last;
      for (int i = 1; i < ONLINE_DELAY; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
      z_out   <= vld_sr[ONLINE_DELAY-1] ? add_z : 2'b00;
      z_valid <= vld_sr[ONLINE_DELAY-1];
      z_last  <= last_sr[ONLINE_DELAY-1];
    end
  end

endmodule

// File: doc/online_add_sched.md
ONLINE_ADD_SCHED -- requirements
Module: online_add_sched

Interface
REQ-001 SHALL have parameter UNROLLING, default 64: operand length in digits; legal range 2..1024.
REQ-002 SHALL have parameter ONLINE_DELAY, default 2: cycles from digit presented on add_x/add_y to matching digit on add_z; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-004 SHALL have port asyn_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports req0, req1, input, 1 bit each: requester wants one addition.
REQ-006 SHALL have ports gnt0, gnt1, output, 1 bit each: requester owns the adder.
REQ-007 SHALL have ports x0_in, y0_in, x1_in, y1_in, input, 2 bits each: signed digit {plus,minus}, MSB-first.
REQ-008 SHALL have port dig_rdy, output, 1 bit: granted requester's digit is consumed this cycle.
REQ-009 SHALL have ports add_x, add_y, output, 2 bits each: digits to the shared online adder.
REQ-010 SHALL have port add_clr, output, 1 bit: active-high clear pulse to the adder.
REQ-011 SHALL have port add_z, input, 2 bits: adder result digit.
REQ-012 SHALL have ports z_out (2 bits), z_valid, z_last, busy, err, all outputs: result stream to the granted requester, plus status.

Function
REQ-013 SHALL implement states IDLE, CLR, STREAM, FLUSH, DRAIN, DONE.
REQ-014 IDLE: req0/req1 sampled; either high -> CLR with grant latched; neither high -> stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: a single requester wins; if both request, the one not served last wins; after reset, req0 has priority.
REQ-016 gntN SHALL be high from CLR through DONE inclusive; req is ignored outside IDLE, so dropping req mid-operation does not abort.
REQ-017 CLR SHALL last 1 cycle, with add_clr=1 and add_x=add_y=2'b00, then go to STREAM.
REQ-018 STREAM SHALL last exactly UNROLLING cycles with dig_rdy=1; the granted requester's x/y digit is registered onto add_x/add_y the next cycle.
REQ-019 FLUSH SHALL last exactly ONLINE_DELAY cycles, with dig_rdy=0 and 2'b00 digits registered onto add_x/add_y.
REQ-020 DRAIN SHALL hold add_x=add_y=2'b00 until the cycle z_last=1, then go to DONE; DONE lasts 1 cycle, updates the last-served pointer, then goes to IDLE.
REQ-021 Timing: if the first STREAM cycle is T, then digit j is on add_x/add_y at T+1+j, and add_z is registered to z_out at T+2+ONLINE_DELAY+j.
REQ-022 z_valid SHALL be high for exactly UNROLLING+ONLINE_DELAY consecutive cycles; z_last SHALL be high on the final one only.
REQ-023 busy SHALL be 0 only in IDLE.
REQ-024 Digit and delay counters SHALL be sized by $clog2 of their parameter and SHALL NOT wrap within an operation.
REQ-025 Outputs are meaningful only to the granted requester; a non-granted requester SHALL see dig_rdy, z_valid and z_last low.

Reset
REQ-026 Asserting asyn_reset_n low SHALL immediately force the following: state IDLE; gnt0=gnt1=0; dig_rdy=0; add_x=add_y=2'b00; add_clr=0; z_out=2'b00; z_valid=z_last=busy=err=0; last-served pointer = requester 1 (so req0 wins first).
REQ-027 Reset mid-operation SHALL abandon the operation without emitting z_last; the first grant after reset SHALL pass through CLR.

Configuration
REQ-028 Macro ONLINE_ADD_SCHED_DIGIT_CHECK_EN, when defined: an illegal input digit 2'b11 accepted in STREAM SHALL be replaced by 2'b00 on add_x/add_y; err SHALL be set sticky on the following cycle and cleared only by the next CLR or reset.
REQ-029 Without the macro, digits SHALL pass unchanged and err SHALL be constant 0.

Verification (UNROLLING=4, ONLINE_DELAY=2)
REQ-030 Reset, then req0 pulsed 1 cycle -> gnt0 high for 1+4+2+DRAIN+1 cycles; dig_rdy high 4 cycles; z_valid high 6 cycles; z_last only on the 6th; busy low afterwards.
REQ-031 req0=req1=1 held continuously -> grants alternate gnt0, gnt1, gnt0; each operation preceded by one add_clr pulse.
REQ-032 x0_in digits 2'b10 and y0_in digits 2'b00 for all 4 digits -> add_x shows 10,10,10,10,00,00 at T+1..T+6; the z_out stream matches the reference online-adder model for value 15/16.
REQ-033 asyn_reset_n pulled low at T+3 of an operation -> all outputs go to reset values that cycle; no z_last is seen; a new req1 is then served cleanly.
REQ-034 With ONLINE_ADD_SCHED_DIGIT_CHECK_EN defined, x0_in=2'b11 on digit 1 -> add_x=2'b00 at T+2 and err=1 from T+2 until the next CLR; without the macro, add_x=2'b11 and err stays 0.
